// File: rtl/scr1_dmem_port_adapter.sv
// Data-side front end for the dual-port TCM RAM: checks core dmem requests,
// drives RAM port B combinationally and returns a one-cycle pipelined response.
module scr1_dmem_port_adapter #(
    parameter int          SCR1_WIDTH = 32,
    parameter logic [31:0] SCR1_SIZE  = 32'h00010000,
    parameter logic [31:0] SCR1_BASE  = 32'h00480000,
    parameter int          AW         = $clog2(SCR1_SIZE)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    dmem_req,
    output logic                    dmem_req_ack,
    input  logic                    dmem_cmd,
    input  logic [1:0]              dmem_width,
    input  logic [31:0]             dmem_addr,
    input  logic [SCR1_WIDTH-1:0]   dmem_wdata,
    output logic [SCR1_WIDTH-1:0]   dmem_rdata,
    output logic [1:0]              dmem_resp,
    output logic                    mem_renb,
    output logic                    mem_wenb,
    output logic [SCR1_WIDTH/8-1:0] mem_webb,
    output logic [AW-3:0]           mem_addrb,
    output logic [SCR1_WIDTH-1:0]   mem_datab,
    input  logic [SCR1_WIDTH-1:0]   mem_qb
);

    localparam int BW = SCR1_WIDTH / 8;

    typedef enum logic [1:0] {
        W_BYTE    = 2'd0,
        W_HALF    = 2'd1,
        W_WORD    = 2'd2,
        W_ILLEGAL = 2'd3
    } width_e;

    typedef enum logic [1:0] {
        RESP_IDLE = 2'd0,
        RESP_OK   = 2'd1,
        RESP_ERR  = 2'd2
    } resp_e;

    logic          acc;
    logic [1:0]    off;
    logic          inr;
    logic          mis;
    logic          err;
    logic [BW-1:0] be;

    logic          r_vld;
    logic          r_err;
    logic          r_rd;
    logic [1:0]    r_off;
    width_e        r_w;

    logic [SCR1_WIDTH-1:0] q_shift;

    assign dmem_req_ack = !rst;
    assign acc          = dmem_req & dmem_req_ack;
    assign off          = dmem_addr[1:0];
    assign inr          = (dmem_addr & ~(SCR1_SIZE - 32'd1)) == SCR1_BASE;
    assign err          = !inr | mis;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        mis = 1'b0;
        be  = '1;
        case (width_e'(dmem_width))
            W_BYTE:    be  = BW'(4'b0001) << off;
            W_HALF:    begin
                be  = BW'(4'b0011) << off;
                mis = off[0];
            end
            W_WORD:    mis = (off != 2'd0);
            W_ILLEGAL: mis = 1'b1;
            default:   mis = 1'b1;
        endcase
    end

    assign mem_addrb = dmem_addr[AW-1:2];
    assign mem_renb  = acc & !err & !dmem_cmd;
    assign mem_wenb  = acc & !err & dmem_cmd;
    assign mem_webb  = mem_wenb ? be : '0;
    assign mem_datab = dmem_wdata << {off, 3'b000};

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= 1'b0;
            r_err <= 1'b0;
            r_rd  <= 1'b0;
            r_off <= 2'd0;
            r_w   <= W_BYTE;
        end else begin
            r_vld <= acc;
            r_err <= err;
            r_rd  <= !dmem_cmd;
            r_off <= off;
            r_w   <= width_e'(dmem_width);
        end
    end

    assign q_shift = mem_qb >> {r_off, 3'b000};

    always_comb begin
        dmem_resp  = RESP_IDLE;
        dmem_rdata = '0;
        if (r_vld) begin
            dmem_resp = r_err ? RESP_ERR : RESP_OK;
            if (!r_err && r_rd) begin
                case (r_w)
                    W_BYTE:  dmem_rdata = SCR1_WIDTH'(q_shift[7:0]);
                    W_HALF:  dmem_rdata = SCR1_WIDTH'(q_shift[15:0]);
                    default: dmem_rdata = q_shift;
                endcase
            end
        end
    end

endmodule
